synapse_psc: RTL and testbench

- Weighted synapse stage between the presynaptic neuron and the postsynaptic neuron.
- Converts each presynaptic spike, scaled by the current STDP weight, into a post-synaptic current that decays exponentially. This replaces the raw input current that would otherwise drive the postsynaptic neuron.
- `current` drives the postsynaptic neuron's current input directly. `weight` comes from the STDP block.

---
 rtl/synapse_psc.sv | 122 ++++++++++++
 tb/tb_synapse_psc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_psc.sv
// rtl/synapse_psc.sv - weighted synapse producing an exponentially decaying post-synaptic current (optional axonal delay: SYN_DELAY_EN)
module synapse_psc #(
    parameter int WIDTH        = 8,
    parameter int DECAY_SHIFT  = 3,
    parameter int DECAY_PERIOD = 4,
    parameter int DELAY        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_spike,
    input  logic [WIDTH-1:0] weight,
    output logic [WIDTH-1:0] current,
    output logic             active,
    output logic [7:0]       spike_cnt
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       dcnt;
    logic [7:0]       dcnt_next;
    logic             spike_int;
    logic             tick;
    logic [WIDTH-1:0] decay_step;
    logic [WIDTH-1:0] decayed;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] current_next;
    logic [7:0]       cnt_next;

`ifdef SYN_DELAY_EN
    logic [DELAY-1:0] dly;

    // Axonal delay: spikes shift through DELAY stages; each in-flight spike keeps its own slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '0;
        end else begin
            dly <= (dly << 1) | DELAY'(pre_spike);
        end
    end

    assign spike_int = dly[DELAY-1];
`else
    // Without the delay line the spike is integrated directly; DELAY has no effect here
    if (DELAY < 1) begin : g_delay_unused
    end

    assign spike_int = pre_spike;
`endif

    // Decay and add datapath: decay (if ticking) first, then add the weight with saturation
    always_comb begin
        tick         = (state == ACTIVE) && (dcnt == 8'(DECAY_PERIOD - 1));
        decay_step   = current >> DECAY_SHIFT;
        decayed      = current - decay_step;
        // Small currents would never shrink by the shifted step; force a unit step so they reach 0
        if ((decay_step == '0) && (current != '0)) begin
            decayed = current - WIDTH'(1);
        end
        base         = tick ? decayed : current;
        sum          = {1'b0, base} + {1'b0, weight};
        current_next = base;
        cnt_next     = spike_cnt;
        if (spike_int) begin
            current_next = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
            if (spike_cnt != 8'hFF) begin
                cnt_next = spike_cnt + 8'd1;
            end
        end
    end

    // Next-state logic: ACTIVE while the current is nonzero; decay counter runs only in ACTIVE
    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        case (state)
            IDLE: begin
                dcnt_next = 8'd0;
                if (current_next != '0) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (current_next == '0) begin
                    state_next = IDLE;
                    dcnt_next  = 8'd0;
                end else if (tick) begin
                    dcnt_next = 8'd0;
                end else begin
                    dcnt_next = dcnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                dcnt_next  = 8'd0;
            end
        endcase
    end

    // State, counter and output registers; active is derived from current_next so it tracks current
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dcnt      <= 8'd0;
            current   <= '0;
            active    <= 1'b0;
            spike_cnt <= 8'd0;
        end else begin
            state     <= state_next;
            dcnt      <= dcnt_next;
            current   <= current_next;
            active    <= (current_next != '0);
            spike_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_synapse_psc.sv
// tb/tb_synapse_psc.sv - self-checking bench for synapse_psc (directed tables plus randomized model comparison)
module tb_synapse_psc;

    localparam int DLY = 3;

    logic       clk;
    logic       rst_n;
    logic       pre_spike;
    logic [7:0] weight;
    logic [7:0] cur [3];
    logic       act [3];
    logic [7:0] cnt [3];

    int n_chk;
    int n_pass;

    // Reference model state: current, spike count, cycles spent in ACTIVE since entry
    int m_cur   [3];
    int m_cnt   [3];
    int m_phase [3];
    bit hist    [16];
    int shf [3] = '{3, 2, 3};
    int per [3] = '{4, 1, 255};

    typedef struct {
        bit spk;
        int w;
        int exp_cur;
        bit exp_act;
    } vec_t;

    vec_t tbl [18];
    int   dv  [18] = '{100, 75, 57, 43, 33, 25, 19, 15, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};

    synapse_psc #(.WIDTH(8), .DECAY_SHIFT(3), .DECAY_PERIOD(4), .DELAY(DLY)) dut_a (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .weight(weight),
        .current(cur[0]), .active(act[0]), .spike_cnt(cnt[0])
    );

    synapse_psc #(.WIDTH(8), .DECAY_SHIFT(2), .DECAY_PERIOD(1), .DELAY(DLY)) dut_b (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .weight(weight),
        .current(cur[1]), .active(act[1]), .spike_cnt(cnt[1])
    );

    synapse_psc #(.WIDTH(8), .DECAY_SHIFT(3), .DECAY_PERIOD(255), .DELAY(DLY)) dut_c (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .weight(weight),
        .current(cur[2]), .active(act[2]), .spike_cnt(cnt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        n_chk++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cur[k]   = 0;
            m_cnt[k]   = 0;
            m_phase[k] = 0;
        end
        for (int i = 0; i < 16; i++) hist[i] = 1'b0;
    endtask

    function automatic int decay_of(input int c, input int s);
        int d;
        d = c >> s;
        if (d == 0 && c != 0) d = 1;
        return c - d;
    endfunction

    task automatic model_edge(input bit spk, input int w);
        bit integ;
        if (!rst_n) begin
            model_reset();
            return;
        end
`ifdef SYN_DELAY_EN
        integ = hist[DLY-1];
        for (int i = DLY - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = spk;
`else
        integ = spk;
`endif
        for (int k = 0; k < 3; k++) begin
            int c;
            int n;
            c = m_cur[k];
            n = c;
            if (c != 0 && (m_phase[k] % per[k]) == per[k] - 1) n = decay_of(c, shf[k]);
            if (integ) begin
                n = n + w;
                if (n > 255) n = 255;
                if (m_cnt[k] < 255) m_cnt[k]++;
            end
            if (c == 0 || n == 0) m_phase[k] = 0;
            else m_phase[k]++;
            m_cur[k] = n;
        end
    endtask

    task automatic cmp_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cur[%0d]", k), int'(cur[k]), m_cur[k]);
            chk($sformatf("active[%0d]", k), int'(act[k]), int'(m_cur[k] != 0));
            chk($sformatf("spike_cnt[%0d]", k), int'(cnt[k]), m_cnt[k]);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare 1ns later
    task automatic cycle(input bit spk, input int w);
        pre_spike = spk;
        weight    = 8'(w);
        @(posedge clk);
        model_edge(spk, w);
        #1;
        cmp_model();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear with no clock edge
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_rst_cur[%0d]", k), int'(cur[k]), 0);
            chk($sformatf("async_rst_act[%0d]", k), int'(act[k]), 0);
            chk($sformatf("async_rst_cnt[%0d]", k), int'(cnt[k]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        pre_spike = 1'b0;
        weight    = 8'd0;
        model_reset();

        tbl[0] = '{spk: 1'b1, w: 100, exp_cur: 100, exp_act: 1'b1};
        for (int i = 1; i < 18; i++) tbl[i] = '{spk: 1'b0, w: 0, exp_cur: dv[i], exp_act: (dv[i] != 0)};

        // Spikes while held in reset are ignored
        cycle(1'b1, 50);
        cycle(1'b1, 50);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_hold_cur[%0d]", k), int'(cur[k]), 0);
            chk($sformatf("rst_hold_cnt[%0d]", k), int'(cnt[k]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Build up a current, then clear it asynchronously
        cycle(1'b1, 50);
        for (int i = 0; i < 3; i++) cycle(1'b0, 50);
        chk("pre_async_cur_c", int'(cur[2]), 50);
        async_reset();

`ifndef SYN_DELAY_EN
        // Decay sequence on the SHIFT=2, PERIOD=1 instance
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].spk, tbl[i].w);
            chk($sformatf("decay_cur_row%0d", i), int'(cur[1]), tbl[i].exp_cur);
            chk($sformatf("decay_act_row%0d", i), int'(act[1]), int'(tbl[i].exp_act));
        end

        // Decay tick and spike in the same cycle
        async_reset();
        cycle(1'b1, 100);
        chk("simul_pre_cur_b", int'(cur[1]), 100);
        cycle(1'b1, 10);
        chk("simul_cur_b", int'(cur[1]), 85);

        // Saturation on the long-period instance
        async_reset();
        cycle(1'b1, 200);
        chk("sat_first_cur_c", int'(cur[2]), 200);
        cycle(1'b1, 200);
        chk("sat_cur_c", int'(cur[2]), 255);
        chk("sat_cnt_c", int'(cnt[2]), 2);

        // Zero-weight spike from IDLE, then period-4 hold and first decay step
        async_reset();
        cycle(1'b1, 0);
        chk("w0_cur_a", int'(cur[0]), 0);
        chk("w0_act_a", int'(act[0]), 0);
        chk("w0_cnt_a", int'(cnt[0]), 1);
        cycle(1'b1, 80);
        chk("hold0_cur_a", int'(cur[0]), 80);
        for (int i = 1; i < 4; i++) begin
            cycle(1'b0, 0);
            chk($sformatf("hold%0d_cur_a", i), int'(cur[0]), 80);
        end
        cycle(1'b0, 0);
        chk("period_decay_cur_a", int'(cur[0]), 70);
`else
        // Two in-flight spikes exit DELAY edges later, weight sampled on exit
        async_reset();
        cycle(1'b1, 40);
        cycle(1'b1, 40);
        cycle(1'b0, 40);
        chk("dly_edge2_cur_c", int'(cur[2]), 0);
        cycle(1'b0, 40);
        chk("dly_edge3_cur_c", int'(cur[2]), 40);
        cycle(1'b0, 40);
        chk("dly_edge4_cur_c", int'(cur[2]), 80);
        chk("dly_cnt_c", int'(cnt[2]), 2);

        // Reset with spikes still in flight discards them
        async_reset();
        cycle(1'b1, 40);
        cycle(1'b1, 40);
        async_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 40);
            chk($sformatf("dly_rst_cur_c%0d", i), int'(cur[2]), 0);
        end
`endif

        // Saturating burst
        async_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 255);
        chk("burst_cur_c", int'(cur[2]), 255);

        // Randomized traffic against the model, with occasional async resets
        for (int i = 0; i < 4000; i++) begin
            bit spk;
            int w;
            spk = ($urandom_range(0, 2) == 0);
            w   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            cycle(spk, w);
            if (i % 1300 == 1299) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
